calc_sequencer: RTL

//  Key-event controller for the hex calculator. It accepts digit, operator and equals events and

---
 rtl/calc_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Key-event sequencer for a hex calculator: digit entry, operator chaining,
// repeat-equals, and one shared add/sub/pass/shift-add-multiply datapath.
module calc_sequencer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         newhex,
  input  logic [3:0]   hexcode,
  input  logic         newop,
  input  logic [1:0]   opcode,
  input  logic         eq,
  output logic [W-1:0] display,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         key_drop,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_entry;
  logic [W-1:0]    r_acc;
  logic            r_flow;
  logic            r_pend_valid;
  logic [1:0]      r_pend_op;
  logic            r_after_eq;
  logic [1:0]      r_exec_op;
  logic            r_done;
  logic            r_ovf;
  logic            r_key_drop;
  logic [2*W-1:0]  r_prod;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;

  logic            w_any_key;
  logic            w_start;
  logic [1:0]      w_start_op;
  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic [W-1:0]    w_exec_res;
  logic            w_exec_ovf;
  logic [2*W-1:0]  w_prod_next;

  assign w_any_key = eq | newop | newhex;

  // Execution is launched by eq with a pending op, or by an operator that
  // follows freshly typed digits in the middle of a chain.
  always_comb begin
    w_start    = 1'b0;
    w_start_op = r_pend_op;
    if (r_state == IDLE) begin
      if (eq) begin
        w_start = r_pend_valid;
      end else if (newop) begin
        w_start = r_pend_valid & ~r_flow & ~r_after_eq;
      end
    end
  end

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_entry};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_entry};

  always_comb begin
    w_exec_res = r_entry;
    w_exec_ovf = 1'b0;
    case (r_exec_op)
      OP_ADD: begin
        w_exec_res = w_sum[W-1:0];
        w_exec_ovf = w_sum[W];
      end
      OP_SUB: begin
        w_exec_res = w_diff[W-1:0];
        w_exec_ovf = w_diff[W];
      end
      default: begin
        w_exec_res = r_entry;
        w_exec_ovf = 1'b0;
      end
    endcase
  end

  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_entry      <= '0;
      r_acc        <= '0;
      r_flow       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_op    <= 2'b00;
      r_after_eq   <= 1'b0;
      r_exec_op    <= 2'b00;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_key_drop   <= 1'b0;
      r_prod       <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
    end else begin
      r_done     <= 1'b0;
      r_key_drop <= 1'b0;

      if (w_start) begin
        r_exec_op <= w_start_op;
        r_prod    <= '0;
        r_mcand   <= {{W{1'b0}}, r_acc};
        r_mplier  <= r_entry;
        r_cnt     <= '0;
        r_state   <= (w_start_op == OP_MUL) ? MUL : EXEC;
      end

      case (r_state)
        IDLE: begin
          if (eq) begin
            if (!r_pend_valid) r_acc <= r_entry;
            r_after_eq <= 1'b1;
            r_flow     <= 1'b1;
          end else if (newop) begin
            if (!r_pend_valid) begin
              r_acc        <= r_entry;
              r_pend_valid <= 1'b1;
            end
            r_pend_op  <= opcode;
            r_after_eq <= 1'b0;
            r_flow     <= 1'b1;
          end else if (newhex) begin
            if (r_after_eq) r_pend_valid <= 1'b0;
            if (r_flow) r_entry <= {{(W-4){1'b0}}, hexcode};
            else        r_entry <= {r_entry[W-5:0], hexcode};
            r_flow     <= 1'b0;
            r_after_eq <= 1'b0;
          end
        end
        EXEC: begin
          r_acc   <= w_exec_res;
          r_ovf   <= w_exec_ovf;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[W-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_acc   <= w_prod_next[W-1:0];
            r_ovf   <= |w_prod_next[2*W-1:W];
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Keys arriving mid-operation are discarded, never queued.
      if (r_state != IDLE && w_any_key) r_key_drop <= 1'b1;
    end
  end

  assign display   = r_flow ? r_acc : r_entry;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign key_drop  = r_key_drop;
  assign dbg_state = r_state;

endmodule
